cce_1_32_axis_stall_detector: RTL and testbench
===============================================

# cce_1_32_axis_stall_detector

Producer of per-port AXI-Stream block indications for the CCE_1_32 deadlock monitor. Watches tvalid/tready on NUM_PORTS stream interfaces, times consecutive stall cycles per port, and drives the registered `axis_block_sigs` vector that the monitor consumes. It also emits one latched stall report per blocking episode over a valid/ready handshake for the debug/status path.

## Interface

Parameters:
- NUM_PORTS, 2, number of monitored AXIS ports (1..16)
- STALL_THRESH, 16, consecutive stall cycles before a port is flagged (1..2^CNT_W-1)
- CNT_W, 8, width of each per-port stall counter

Ports:
- clock  in  1  single design clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  detection enable; low clears all state synchronously
- tvalid  in  NUM_PORTS  observed tvalid, bit i = port i
- tready  in  NUM_PORTS  observed tready, bit i = port i
- axis_block_sigs  out  NUM_PORTS  registered per-port block flag, to deadlock monitor
- block_any  out  1  registered OR of axis_block_sigs
- report_valid  out  1  stall report available
- report_ready  in  1  report consumer accept
- report_port  out  4  index of reported port
- report_kind  out  1  0 = backpressure (valid & !ready), 1 = starvation (!valid & ready)

## Operation

- Per-port stall condition: stall_bp[i] = tvalid[i] & !tready[i]; stall_sv[i] = !tvalid[i] & tready[i] (see Configuration). stall[i] = stall_bp[i] | stall_sv[i].
- Counter cnt[i]: increments each cycle stall[i]=1, saturates at 2^CNT_W-1; clears to 0 on any cycle stall[i]=0 (handshake or both idle). Change of stall kind while stalled (bp->sv) also clears to 0.
- axis_block_sigs[i] <= (next cnt[i] >= STALL_THRESH). kind[i] registered with the stall kind current at flag assertion.
- Report FSM, 3 states:
  - IDLE: if any axis_block_sigs bit set, latch lowest set index into report_port, its kind into report_kind -> REPORT.
  - REPORT: report_valid=1; report_port/kind stable; on report_valid & report_ready -> HOLD.
  - HOLD: report_valid=0; wait until axis_block_sigs[report_port]=0 -> IDLE.
- Other ports blocking during REPORT/HOLD are not reported until FSM returns to IDLE; if still blocked then, reported next (lowest index first).
- enable=0: all cnt, axis_block_sigs, block_any cleared, FSM forced to IDLE, report_valid dropped the next cycle (only permitted withdrawal of report_valid).
- Unused report_port upper bits are 0.

## Timing

- Reset (reset_n=0, async): cnt=0, axis_block_sigs=0, block_any=0, report_valid=0, report_port=0, report_kind=0, FSM=IDLE. Reset mid-report abandons the report with no handshake.
- Flag latency: stall sampled on STALL_THRESH consecutive edges -> axis_block_sigs[i]=1 after the STALL_THRESH-th edge; block_any same edge.
- Deassert: first edge sampling stall[i]=0 clears cnt and flag; visible the following cycle.
- report_valid rises one cycle after the flag rises (IDLE->REPORT edge).
- Handshake: accept on edge with both high; report_valid low the next cycle. Consumer may hold report_ready high continuously; minimum episode = 1 report cycle + 1 HOLD cycle.
- Simultaneous: flag clearing on the same edge as acceptance -> HOLD exits to IDLE one cycle later.
- STALL_THRESH=1: flag asserted after first stalled edge.

## Configuration

- CCE_STALL_STARVE_EN defined: starvation (!tvalid & tready) counts as stall, report_kind may be 1.
- Not defined: stall_sv forced to 0; only backpressure is detected; report_kind is constant 0; starvation cycles clear counters like idle cycles.

## Test plan

- Reset: reset_n low with tvalid=1, tready=0 on port 0 -> all outputs 0; release and hold 16 cycles -> axis_block_sigs=2'b01 after the 16th edge, report_valid next cycle, report_port=0, report_kind=0.
- Threshold edge: port 1 stalled 15 cycles then tready=1 for one cycle -> no flag, cnt returns to 0; then 16 stall cycles -> axis_block_sigs[1]=1.
- Arbitration: ports 0 and 1 blocked same cycle, report_ready=1 -> first report port 0; release port 0 -> FSM idles, second report port 1.
- Backpressure on report: report_ready=0 for 10 cycles -> report_valid, report_port, report_kind stable throughout; accept on cycle 11, report_valid=0 next cycle.
- Starvation with CCE_STALL_STARVE_EN: port 0 tvalid=0, tready=1 for 16 cycles -> flag, report_kind=1; without macro -> no flag ever.
- enable drop during REPORT -> report_valid and all flags 0 next cycle, FSM IDLE; re-enable with continued stall -> fresh 16-cycle count before reflag.

Source files
------------

// File: rtl/cce_1_32_axis_stall_detector.sv
// Per-port AXI-Stream stall timer with registered block flags and a one-shot stall report handshake.
// Optional macro CCE_STALL_STARVE_EN adds starvation (!tvalid & tready) as a stall kind.
module cce_1_32_axis_stall_detector #(
  parameter int NUM_PORTS    = 2,
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_PORTS-1:0] tvalid,
  input  logic [NUM_PORTS-1:0] tready,
  output logic [NUM_PORTS-1:0] axis_block_sigs,
  output logic                 block_any,
  output logic                 report_valid,
  input  logic                 report_ready,
  output logic [3:0]           report_port,
  output logic                 report_kind
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REPORT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  logic [NUM_PORTS-1:0] stall_bp_s;
  logic [NUM_PORTS-1:0] stall_sv_s;
  logic [NUM_PORTS-1:0] stall_s;
  logic [CNT_W-1:0]     cnt_r      [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_next_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] flag_next_s;
  logic [NUM_PORTS-1:0] last_kind_r;
  logic [NUM_PORTS-1:0] flag_kind_r;
  logic [NUM_PORTS-1:0] block_r;
  logic                 block_any_r;
  logic [1:0]           state_r;
  logic                 report_valid_r;
  logic [3:0]           report_port_r;
  logic                 report_kind_r;
  logic [15:0]          block_ext_s;
  logic [3:0]           low_idx_s;
  logic                 low_kind_s;

  assign stall_bp_s = tvalid & ~tready;
`ifdef CCE_STALL_STARVE_EN
  assign stall_sv_s = ~tvalid & tready;
`else
  assign stall_sv_s = {NUM_PORTS{1'b0}};
`endif
  assign stall_s = stall_bp_s | stall_sv_s;

  // Next stall count per port: clear on no-stall or on a change of stall kind, else saturating increment
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_next_s[i] = '0;
      if (!stall_s[i]) begin
        cnt_next_s[i] = '0;
      end else if ((cnt_r[i] != '0) && (last_kind_r[i] != stall_sv_s[i])) begin
        cnt_next_s[i] = '0;
      end else if (cnt_r[i] == CNT_MAX_C) begin
        cnt_next_s[i] = cnt_r[i];
      end else begin
        cnt_next_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      flag_next_s[i] = (cnt_next_s[i] >= THRESH_C);
    end
  end

  // Counter, block flag and flag-kind registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_r[i] <= '0;
      last_kind_r <= '0;
      flag_kind_r <= '0;
      block_r     <= '0;
      block_any_r <= 1'b0;
    end else if (!enable) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_r[i] <= '0;
      last_kind_r <= '0;
      flag_kind_r <= '0;
      block_r     <= '0;
      block_any_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_r[i] <= cnt_next_s[i];
      last_kind_r <= (stall_s & stall_sv_s) | (~stall_s & last_kind_r);
      // Kind is captured only on the rising edge of a flag
      flag_kind_r <= (flag_next_s & ~block_r & stall_sv_s) | (~(flag_next_s & ~block_r) & flag_kind_r);
      block_r     <= flag_next_s;
      block_any_r <= |flag_next_s;
    end
  end

  assign block_ext_s = 16'(block_r);

  // Lowest-index blocked port and its kind
  always_comb begin
    low_idx_s  = 4'd0;
    low_kind_s = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (block_r[i]) begin
        low_idx_s  = 4'(i);
        low_kind_s = flag_kind_r[i];
      end else begin
        low_idx_s  = low_idx_s;
        low_kind_s = low_kind_s;
      end
    end
  end

  // Report FSM: latch one report per blocking episode, hold until that port unblocks
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      report_valid_r <= 1'b0;
      report_port_r  <= 4'd0;
      report_kind_r  <= 1'b0;
    end else if (!enable) begin
      state_r        <= ST_IDLE;
      report_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|block_r) begin
            state_r        <= ST_REPORT;
            report_valid_r <= 1'b1;
            report_port_r  <= low_idx_s;
            report_kind_r  <= low_kind_s;
          end else begin
            state_r        <= ST_IDLE;
            report_valid_r <= 1'b0;
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            state_r        <= ST_HOLD;
            report_valid_r <= 1'b0;
          end else begin
            state_r        <= ST_REPORT;
            report_valid_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          report_valid_r <= 1'b0;
          if (!block_ext_s[report_port_r]) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          report_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign axis_block_sigs = block_r;
  assign block_any       = block_any_r;
  assign report_valid    = report_valid_r;
  assign report_port     = report_port_r;
  assign report_kind     = report_kind_r;

endmodule

// File: tb/tb_cce_1_32_axis_stall_detector.sv
// Directed bench for cce_1_32_axis_stall_detector with a report scoreboard queue.
module tb_cce_1_32_axis_stall_detector;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] tvalid;
  logic [1:0] tready;
  logic [1:0] axis_block_sigs;
  logic       block_any;
  logic       report_valid;
  logic       report_ready;
  logic [3:0] report_port;
  logic       report_kind;

  typedef struct {
    logic [3:0] port;
    logic       kind;
  } rep_t;

  rep_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  cce_1_32_axis_stall_detector dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .tvalid(tvalid), .tready(tready),
    .axis_block_sigs(axis_block_sigs), .block_any(block_any),
    .report_valid(report_valid), .report_ready(report_ready),
    .report_port(report_port), .report_kind(report_kind)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rep(input logic [3:0] port, input logic kind);
    rep_t r;
    r.port = port;
    r.kind = kind;
    exp_q.push_back(r);
  endtask

  // Wait (bounded) for report_valid, then pop the scoreboard and compare
  task automatic check_report(input string tag);
    rep_t r;
    int   budget;
    budget = 0;
    while (report_valid !== 1'b1 && budget < 20) begin
      tick(1);
      budget++;
    end
    chk({tag, "_valid"}, 32'(report_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      r = exp_q.pop_front();
      chk({tag, "_port"}, 32'(report_port), 32'(r.port));
      chk({tag, "_kind"}, 32'(report_kind), 32'(r.kind));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; tvalid = 2'b01; tready = 2'b00; report_ready = 1'b0;
    tick(3);
    chk("rst_flags", 32'(axis_block_sigs), 32'd0);
    chk("rst_any", 32'(block_any), 32'd0);
    chk("rst_valid", 32'(report_valid), 32'd0);
    chk("rst_port", 32'(report_port), 32'd0);
    chk("rst_kind", 32'(report_kind), 32'd0);
    reset_n = 1'b1;

    tick(15);
    chk("thr15_flags", 32'(axis_block_sigs), 32'd0);
    tick(1);
    chk("thr16_flags", 32'(axis_block_sigs), 32'h1);
    chk("thr16_any", 32'(block_any), 32'd1);
    chk("thr16_valid", 32'(report_valid), 32'd0);
    push_rep(4'd0, 1'b0);
    tick(1);
    check_report("rep0");

    // Consumer backpressure: report must stay stable
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("bp_valid", 32'(report_valid), 32'd1);
      chk("bp_port", 32'(report_port), 32'd0);
      chk("bp_kind", 32'(report_kind), 32'd0);
    end
    report_ready = 1'b1;
    tick(1);
    chk("acc_valid", 32'(report_valid), 32'd0);
    tvalid = 2'b00;
    tick(1);
    chk("rel_flags", 32'(axis_block_sigs), 32'd0);
    chk("rel_any", 32'(block_any), 32'd0);
    tick(2);
    chk("idle_valid", 32'(report_valid), 32'd0);

    // Port 1: 15 stalls, one handshake, must not flag
    tvalid = 2'b10; tready = 2'b00;
    tick(15);
    tready = 2'b10;
    tick(1);
    chk("hs_flags", 32'(axis_block_sigs), 32'd0);
    tready = 2'b00;
    tick(15);
    chk("p1_15_flags", 32'(axis_block_sigs), 32'd0);
    tick(1);
    chk("p1_16_flags", 32'(axis_block_sigs), 32'h2);
    push_rep(4'd1, 1'b0);
    tick(1);
    check_report("rep1");
    tick(1);
    chk("rep1_acc", 32'(report_valid), 32'd0);
    tvalid = 2'b00;
    tick(3);

    // Arbitration: both ports block on the same edge
    tvalid = 2'b11; tready = 2'b00;
    tick(16);
    chk("arb_flags", 32'(axis_block_sigs), 32'h3);
    push_rep(4'd0, 1'b0);
    push_rep(4'd1, 1'b0);
    tick(1);
    check_report("arb_a");
    tick(1);
    chk("arb_hold", 32'(report_valid), 32'd0);
    tvalid = 2'b10;
    tick(1);
    chk("arb_rel0", 32'(axis_block_sigs), 32'h2);
    check_report("arb_b");
    tick(1);
    report_ready = 1'b0;
    tvalid = 2'b00;
    tick(3);

    // Enable drop during REPORT, then fresh count on re-enable
    tvalid = 2'b01;
    tick(16);
    push_rep(4'd0, 1'b0);
    tick(1);
    check_report("en_rep");
    enable = 1'b0;
    tick(1);
    chk("en_valid", 32'(report_valid), 32'd0);
    chk("en_flags", 32'(axis_block_sigs), 32'd0);
    chk("en_any", 32'(block_any), 32'd0);
    enable = 1'b1;
    tick(15);
    chk("reen15_flags", 32'(axis_block_sigs), 32'd0);
    chk("reen15_valid", 32'(report_valid), 32'd0);
    tick(1);
    chk("reen16_flags", 32'(axis_block_sigs), 32'h1);
    push_rep(4'd0, 1'b0);
    check_report("reen_rep");
    report_ready = 1'b1;
    tick(1);
    tvalid = 2'b00; tready = 2'b00;
    tick(3);

    // Starvation on port 0
    tready = 2'b01;
    tick(16);
`ifdef CCE_STALL_STARVE_EN
    chk("sv_flags", 32'(axis_block_sigs), 32'h1);
    push_rep(4'd0, 1'b1);
    check_report("sv_rep");
`else
    chk("sv_flags", 32'(axis_block_sigs), 32'd0);
    tick(4);
    chk("sv_flags_late", 32'(axis_block_sigs), 32'd0);
    chk("sv_valid", 32'(report_valid), 32'd0);
`endif
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
